// File: rtl/pe_pkg.sv
// Shared constants and number-format helpers for the radix-4 butterfly PE.
// Helpers work on a 64-bit scratch width; callers size-cast the results.
package pe_pkg;

    localparam int PE_LATENCY = 6;
    localparam int XW         = 64;

    typedef logic signed [XW-1:0] xword_t;

    typedef struct packed {
        logic          ovf;
        logic [XW-1:0] sm;
    } rs_t;

    // Sign-magnitude (w bits) to two's complement; negative zero maps to 0.
    function automatic xword_t sm2tc(input logic [XW-1:0] v, input int w);
        logic [XW-1:0] mag;
        logic          sgn;
        mag = v & ((XW'(1) << (w - 1)) - XW'(1));
        sgn = ((v >> (w - 1)) & XW'(1)) != XW'(0);
        return sgn ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic logic [XW-1:0] tc2sm(input xword_t x, input int w);
        logic [XW-1:0] mag;
        mag = (x < 0) ? -x : x;
        if (mag == XW'(0)) return XW'(0);
        return (x < 0) ? (mag | (XW'(1) << (w - 1))) : mag;
    endfunction

    // Divide by 2^sh rounding half away from zero, then saturate to w-bit sign-magnitude.
    function automatic rs_t round_sat(input xword_t x, input int sh, input int w);
        rs_t           r;
        logic [XW-1:0] mag;
        logic [XW-1:0] lim;
        logic          neg;
        neg = x < 0;
        mag = neg ? -x : x;
        if (sh > 0) mag = (mag + (XW'(1) << (sh - 1))) >> sh;
        lim   = (XW'(1) << (w - 1)) - XW'(1);
        r.ovf = mag > lim;
        if (r.ovf) mag = lim;
        r.sm = tc2sm(neg ? -$signed(mag) : $signed(mag), w);
        return r;
    endfunction

endpackage

// File: rtl/pe_cmul.sv
// Pipelined twiddle rotation (3 register stages): products, sums, round/saturate.
// With bypass_n=0 the differences pass through the same rounding path unrotated.
module pe_cmul
    import pe_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int TW_WIDTH = 16,
    parameter int SHIFT    = 14
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_ce,
    input  logic signed [WIDTH:0]     i_b,
    input  logic signed [WIDTH:0]     i_d,
    input  logic signed [TW_WIDTH-1:0] i_tr,
    input  logic signed [TW_WIDTH-1:0] i_ti,
    input  logic                      i_conj,
    input  logic                      i_bypass_n,
    output logic [WIDTH-1:0]          o_re,
    output logic [WIDTH-1:0]          o_im,
    output logic                      o_ovf
);

    localparam int PW = WIDTH + TW_WIDTH + 1;
    localparam int SW = PW + 1;

    logic signed [TW_WIDTH-1:0] w_ti;
    logic signed [PW-1:0]       w_pbr, w_pbi, w_pdr, w_pdi;
    logic signed [PW-1:0]       r_pbr, r_pbi, r_pdr, r_pdi;
    logic signed [WIDTH:0]      r_b3, r_d3;
    logic signed [SW-1:0]       r_sr, r_si;
    logic [WIDTH-1:0]           r_re, r_im;
    logic                       r_ovf;
    rs_t                        w_rs_r, w_rs_i;

    assign w_ti  = i_conj ? -i_ti : i_ti;
    assign w_pbr = PW'(i_b) * PW'(i_tr);
    assign w_pbi = PW'(i_b) * PW'(w_ti);
    assign w_pdr = PW'(i_d) * PW'(i_tr);
    assign w_pdi = PW'(i_d) * PW'(w_ti);

    assign w_rs_r = round_sat(XW'(r_sr), SHIFT, WIDTH);
    assign w_rs_i = round_sat(XW'(r_si), SHIFT, WIDTH);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pbr <= '0;
            r_pbi <= '0;
            r_pdr <= '0;
            r_pdi <= '0;
            r_b3  <= '0;
            r_d3  <= '0;
            r_sr  <= '0;
            r_si  <= '0;
            r_re  <= '0;
            r_im  <= '0;
            r_ovf <= 1'b0;
        end else if (i_ce) begin
            r_pbr <= w_pbr;
            r_pbi <= w_pbi;
            r_pdr <= w_pdr;
            r_pdi <= w_pdi;
            r_b3  <= i_b;
            r_d3  <= i_d;
            // Unrotated path is pre-scaled so the shared rounder divides it back exactly.
            r_sr  <= i_bypass_n ? (SW'(r_pbr) - SW'(r_pdi)) : (SW'(r_b3) <<< SHIFT);
            r_si  <= i_bypass_n ? (SW'(r_pbi) + SW'(r_pdr)) : (SW'(r_d3) <<< SHIFT);
            r_re  <= WIDTH'(w_rs_r.sm);
            r_im  <= WIDTH'(w_rs_i.sm);
            r_ovf <= w_rs_r.ovf | w_rs_i.ovf;
        end
    end

    assign o_re  = r_re;
    assign o_im  = r_im;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/pe_pipe.sv
// Radix-2x2 butterfly PE with optional twiddle rotation of the difference terms.
// Six ce-gated stages: convert, butterfly, 3x pe_cmul (a/c delay-matched), output hold.
module pe_pipe
    import pe_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int TW_WIDTH = 16,
    parameter int SHIFT    = 14
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_ce,
    input  logic                    i_in_valid,
    input  logic [WIDTH-1:0]        i_in0,
    input  logic [WIDTH-1:0]        i_in1,
    input  logic [WIDTH-1:0]        i_in2,
    input  logic [WIDTH-1:0]        i_in3,
    input  logic [2*TW_WIDTH-1:0]   i_tf,
    input  logic                    i_bypass_n,
    input  logic                    i_conj,
    input  logic                    i_scale,
    output logic                    o_out_valid,
    output logic [WIDTH-1:0]        o_out0,
    output logic [WIDTH-1:0]        o_out1,
    output logic [WIDTH-1:0]        o_out2,
    output logic [WIDTH-1:0]        o_out3,
    output logic                    o_ovf
);

    logic [PE_LATENCY-1:1]      r_vld;
    logic [3:1]                 r_byp;
    logic [2:1]                 r_cnj;
    logic                       r_scl1;
    logic signed [WIDTH-1:0]    r_x0, r_x1, r_x2, r_x3;
    logic signed [TW_WIDTH-1:0] r_tr1, r_ti1, r_tr2, r_ti2;
    logic signed [WIDTH:0]      w_a, w_b, w_c, w_d;
    logic signed [WIDTH:0]      r_a2, r_b2, r_c2, r_d2, r_a3, r_c3, r_a4, r_c4;
    logic [WIDTH-1:0]           r_a5, r_c5;
    logic                       r_acovf5;
    rs_t                        w_rs_a, w_rs_c;
    logic [WIDTH-1:0]           w_re, w_im;
    logic                       w_cmul_ovf;
    logic                       r_out_valid, r_ovf;
    logic [WIDTH-1:0]           r_out0, r_out1, r_out2, r_out3;

    assign w_a = (WIDTH+1)'(r_x0) + (WIDTH+1)'(r_x1);
    assign w_b = (WIDTH+1)'(r_x0) - (WIDTH+1)'(r_x1);
    assign w_c = (WIDTH+1)'(r_x2) + (WIDTH+1)'(r_x3);
    assign w_d = (WIDTH+1)'(r_x2) - (WIDTH+1)'(r_x3);

    assign w_rs_a = round_sat(XW'(r_a4), 0, WIDTH);
    assign w_rs_c = round_sat(XW'(r_c4), 0, WIDTH);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld    <= '0;
            r_byp    <= '0;
            r_cnj    <= '0;
            r_scl1   <= 1'b0;
            r_x0     <= '0;
            r_x1     <= '0;
            r_x2     <= '0;
            r_x3     <= '0;
            r_tr1    <= '0;
            r_ti1    <= '0;
            r_tr2    <= '0;
            r_ti2    <= '0;
            r_a2     <= '0;
            r_b2     <= '0;
            r_c2     <= '0;
            r_d2     <= '0;
            r_a3     <= '0;
            r_c3     <= '0;
            r_a4     <= '0;
            r_c4     <= '0;
            r_a5     <= '0;
            r_c5     <= '0;
            r_acovf5 <= 1'b0;
        end else if (i_ce) begin
            r_vld    <= {r_vld[PE_LATENCY-2:1], i_in_valid};
            r_byp    <= {r_byp[2:1], i_bypass_n};
            r_cnj    <= {r_cnj[1], i_conj};
            r_scl1   <= i_scale;
            r_x0     <= WIDTH'(sm2tc(XW'(i_in0), WIDTH));
            r_x1     <= WIDTH'(sm2tc(XW'(i_in1), WIDTH));
            r_x2     <= WIDTH'(sm2tc(XW'(i_in2), WIDTH));
            r_x3     <= WIDTH'(sm2tc(XW'(i_in3), WIDTH));
            r_tr1    <= TW_WIDTH'(sm2tc(XW'(i_tf[2*TW_WIDTH-1:TW_WIDTH]), TW_WIDTH));
            r_ti1    <= TW_WIDTH'(sm2tc(XW'(i_tf[TW_WIDTH-1:0]), TW_WIDTH));
            r_tr2    <= r_tr1;
            r_ti2    <= r_ti1;
            r_a2     <= r_scl1 ? (w_a >>> 1) : w_a;
            r_b2     <= r_scl1 ? (w_b >>> 1) : w_b;
            r_c2     <= r_scl1 ? (w_c >>> 1) : w_c;
            r_d2     <= r_scl1 ? (w_d >>> 1) : w_d;
            r_a3     <= r_a2;
            r_c3     <= r_c2;
            r_a4     <= r_a3;
            r_c4     <= r_c3;
            r_a5     <= WIDTH'(w_rs_a.sm);
            r_c5     <= WIDTH'(w_rs_c.sm);
            r_acovf5 <= w_rs_a.ovf | w_rs_c.ovf;
        end
    end

    pe_cmul #(
        .WIDTH    (WIDTH),
        .TW_WIDTH (TW_WIDTH),
        .SHIFT    (SHIFT)
    ) u_cmul (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ce       (i_ce),
        .i_b        (r_b2),
        .i_d        (r_d2),
        .i_tr       (r_tr2),
        .i_ti       (r_ti2),
        .i_conj     (r_cnj[2]),
        .i_bypass_n (r_byp[3]),
        .o_re       (w_re),
        .o_im       (w_im),
        .o_ovf      (w_cmul_ovf)
    );

    // Output word only changes when a valid sample lands; otherwise it holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out0      <= '0;
            r_out1      <= '0;
            r_out2      <= '0;
            r_out3      <= '0;
            r_ovf       <= 1'b0;
        end else if (i_ce) begin
            r_out_valid <= r_vld[PE_LATENCY-1];
            if (r_vld[PE_LATENCY-1]) begin
                r_out0 <= r_a5;
                r_out1 <= r_c5;
                r_out2 <= w_re;
                r_out3 <= w_im;
                r_ovf  <= r_acovf5 | w_cmul_ovf;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out0      = r_out0;
    assign o_out1      = r_out1;
    assign o_out2      = r_out2;
    assign o_out3      = r_out3;
    assign o_ovf       = r_ovf;

endmodule

// File: doc/pe_pipe.md
PE_PIPE -- requirements
Module: pe_pipe

Interface
REQ-001 Parameter WIDTH, default 16: data word width, sign-magnitude (MSB sign, WIDTH-1 magnitude bits).
REQ-002 Parameter TW_WIDTH, default 16: width of each twiddle component, sign-magnitude.
REQ-003 Parameter SHIFT, default 14: product right-shift, so twiddle magnitude 2^SHIFT = 1.0; legal range 1..TW_WIDTH-1.
REQ-004 Clk  in  1  sole clock, rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 ce  in  1  pipeline advance enable.
REQ-007 in_valid  in  1  input sample valid.
REQ-008 in0, in1, in2, in3  in  WIDTH each  butterfly inputs, sign-magnitude.
REQ-009 tf  in  2*TW_WIDTH  twiddle {tr in upper half, ti in lower half}, sign-magnitude.
REQ-010 bypass_n  in  1  0 = out2/out3 carry unrotated differences.
REQ-011 conj  in  1  1 = use conjugate twiddle (tr - j*ti) for inverse transform.
REQ-012 scale  in  1  1 = halve butterfly sums and differences.
REQ-013 out_valid  out  1  output sample valid.
REQ-014 out0, out1, out2, out3  out  WIDTH each  results, sign-magnitude.
REQ-015 ovf  out  1  saturation occurred in this output sample.

Function
REQ-016 Inputs convert to two's complement; negative zero (sign=1, magnitude=0) SHALL be treated as 0.
REQ-017 Butterfly SHALL use WIDTH+1-bit arithmetic: a=in0+in1, b=in0-in1, c=in2+in3, d=in2-in3; with scale=1, each SHALL be arithmetic-shifted right by 1 (floor).
REQ-018 out0=a, out1=c; out2=b, out3=d when bypass_n=0.
REQ-019 With bypass_n=1: out2 = round((b*tr - d*ti') / 2^SHIFT), out3 = round((b*ti' + d*tr) / 2^SHIFT), where ti' = -ti if conj=1, else ti; full-precision products and sums.
REQ-020 Rounding SHALL be round-half-away-from-zero on the magnitude.
REQ-021 Any result with magnitude > 2^(WIDTH-1)-1 SHALL saturate to that magnitude, sign kept; ovf=1 if any of the four saturated.
REQ-022 Outputs SHALL never encode negative zero; zero results are emitted as all-zeros.
REQ-023 bypass_n, conj, scale SHALL be sampled with their data word and travel with it through the pipeline, giving per-sample mode changes with no bubbles.
REQ-024 Latency SHALL be exactly 6 enabled cycles (ce=1 edges) from in_valid sampled high to out_valid high; throughput one sample per enabled cycle.
REQ-025 ce=0 SHALL freeze every pipeline register, out_valid included; the input is not sampled.
REQ-026 out0..out3 and ovf SHALL hold their last values while out_valid=0.

Reset
REQ-027 Reset_n=0 SHALL asynchronously clear all pipeline registers; out_valid, ovf, out0..out3 go to 0 immediately.
REQ-028 Samples in flight at reset SHALL be discarded; the first sample after reset release appears 6 enabled cycles after acceptance.

Structure
REQ-029 Shared package pe_pkg SHALL hold: PE_LATENCY=6, sign-magnitude<->two's-complement conversion functions, and the round/saturate function.
REQ-030 Complex multiply, round and saturate SHALL live in sub-module pe_cmul (pipelined, parameters WIDTH, TW_WIDTH, SHIFT); the delay-matched a/c path and valid/mode shift registers stay in pe_pipe.

Verification (WIDTH=16, TW_WIDTH=16, SHIFT=14)
REQ-031 in0=100, in1=30, in2=0x8032, in3=20, tf={16384,0}, bypass_n=1 -> 6 cycles later: out0=130, out1=0x801E, out2=70, out3=0x8046, ovf=0.
REQ-032 Same data, tf={0,0xC000} (-j): out2=0x8046, out3=0x8046; same tf with conj=1 -> out2=70, out3=70.
REQ-033 in0=in1=32767, scale=0 -> out0=0x7FFF, ovf=1; same with scale=1 -> out0=0x7FFF, ovf=0.
REQ-034 Rounding: b=3 (in0=3, in1=0, in2=in3=0), tf={8192,0} -> out2=2; b=-3 -> out2=0x8002; in0=0x8000, in1=0 -> out0=0x0000.
REQ-035 Back-to-back samples with alternating bypass_n and ce=0 for 3 cycles mid-stream -> each output matches its own mode; latency stretches by exactly 3 cycles.
REQ-036 Assert Reset_n=0 between clock edges with 4 samples in flight -> outputs and out_valid clear at once; no stale out_valid after release.
